// File: rtl/dff_en.sv
// Enabled D register with async active-low reset, inverted output and a one-cycle change strobe.
// Optional synchronous clear port is compiled in when DFF_EN_SYNC_CLR_EN is defined.
module dff_en #(
    parameter int          WIDTH       = 1,
    parameter logic [63:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef DFF_EN_SYNC_CLR_EN
    input  logic             clr,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             changed
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;

    // Ternary on en merges D and q_q bitwise, so an unknown enable poisons Q instead of loading data.
    always_comb begin
        q_d   = q_q;
        chg_d = 1'b0;
`ifdef DFF_EN_SYNC_CLR_EN
        if (clr) begin
            q_d   = RST_V;
            chg_d = (q_q != RST_V);
        end else begin
            q_d   = en ? D : q_q;
            chg_d = en & (D != q_q);
        end
`else
        q_d   = en ? D : q_q;
        chg_d = en & (D != q_q);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= RST_V;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign Q       = q_q;
    assign Qn      = ~q_q;
    assign changed = chg_q;

endmodule

// File: tb/tb_dff_en.sv
// Randomized bench for dff_en: a 1-bit/reset-0 instance and an 8-bit/reset-A5 instance
// checked every cycle against a rule-level model kept in the bench.
module tb_dff_en;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
`ifdef DFF_EN_SYNC_CLR_EN
    logic       clr = 1'b0;
`endif
    logic       d1  = 1'b0;
    logic [7:0] d8  = 8'h00;
    logic       q1, qn1, ch1;
    logic [7:0] q8, qn8;
    logic       ch8;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: what each register should hold and whether the last edge altered it.
    logic       m1,  m1c;
    logic [7:0] m8;
    logic       m8c;

    always #50 clk = ~clk;

    dff_en #(.WIDTH(1), .RESET_VALUE(64'h0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en),
`ifdef DFF_EN_SYNC_CLR_EN
        .clr(clr),
`endif
        .D(d1), .Q(q1), .Qn(qn1), .changed(ch1)
    );

    dff_en #(.WIDTH(8), .RESET_VALUE(64'hA5)) u_dut8 (
        .clk(clk), .rst(rst), .en(en),
`ifdef DFF_EN_SYNC_CLR_EN
        .clr(clr),
`endif
        .D(d8), .Q(q8), .Qn(qn8), .changed(ch8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        logic       e_qn1;
        logic [7:0] e_qn8;
        e_qn1 = ~m1;
        e_qn8 = ~m8;
        check({tag, "_q1"},  64'(q1),  64'(m1));
        check({tag, "_qn1"}, 64'(qn1), 64'(e_qn1));
        check({tag, "_ch1"}, 64'(ch1), 64'(m1c));
        check({tag, "_q8"},  64'(q8),  64'(m8));
        check({tag, "_qn8"}, 64'(qn8), 64'(e_qn8));
        check({tag, "_ch8"}, 64'(ch8), 64'(m8c));
    endtask

    task automatic model_reset();
        m1 = 1'b0; m1c = 1'b0;
        m8 = 8'hA5; m8c = 1'b0;
    endtask

    task automatic model_edge();
        logic do_clr;
        do_clr = 1'b0;
`ifdef DFF_EN_SYNC_CLR_EN
        do_clr = clr;
`endif
        if (!rst) begin
            model_reset();
        end else if (do_clr) begin
            m1c = (m1 != 1'b0);  m1 = 1'b0;
            m8c = (m8 != 8'hA5); m8 = 8'hA5;
        end else if (en) begin
            m1c = (d1 != m1); m1 = d1;
            m8c = (d8 != m8); m8 = d8;
        end else begin
            m1c = 1'b0;
            m8c = 1'b0;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_rst(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        m1 = 1'bx; m1c = 1'bx; m8 = 8'hxx; m8c = 1'bx;

        // Reset asserted before any clock edge must act immediately.
        #10;
        async_rst("por");
        en = 1'b1; d1 = 1'b1; d8 = 8'hFF;
        tick("rst_hold_a");
        tick("rst_hold_b");
        rst = 1'b1;
        #10;
        check_all("release_noedge");

        en = 1'b0; d1 = 1'b1; d8 = 8'hFF;
        for (int i = 0; i < 3; i++) tick("hold_en0");

        en = 1'b1; d1 = 1'b1; d8 = 8'h3C;
        tick("capture");
        tick("capture_same1");
        tick("capture_same2");

        en = 1'b0; d1 = 1'b0; d8 = 8'h00;
        tick("endrop1");
        tick("endrop2");

        #29;
        async_rst("midcycle_rst");
        en = 1'b1; d1 = 1'b1; d8 = 8'hFF;
        tick("rst_vs_en1");
        tick("rst_vs_en2");
        rst = 1'b1;
        tick("after_release");

`ifdef DFF_EN_SYNC_CLR_EN
        en = 1'b1; d8 = 8'h3C;
        tick("pre_clr");
        clr = 1'b1; d8 = 8'hFF; d1 = 1'b1;
        tick("clr");
        tick("clr_again");
        clr = 1'b0;
`endif

        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            d1 = 1'($urandom_range(0, 1));
            d8 = ($urandom_range(0, 3) == 0) ? m8 : 8'($urandom);
`ifdef DFF_EN_SYNC_CLR_EN
            clr = ($urandom_range(0, 7) == 0);
`endif
            if (!rst && $urandom_range(0, 2) == 0) begin
                rst = 1'b1;
            end else if (rst && $urandom_range(0, 19) == 0) begin
                #29;
                async_rst("rnd_rst");
            end
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dff_en.md
Name: dff_en

Overview:
- Parameterizable D-type register with clock enable and asynchronous active-low reset.
- Basic storage primitive for pipeline stages, control flags and configuration bits.
- Adds an inverted output and a one-cycle "value changed" strobe so downstream logic needs no extra edge-detect flops.
- Instantiated wherever a gated, resettable flop is needed.

Parameters:
- WIDTH, 1, bit width of D, Q and Qn (legal range 1..64).
- RESET_VALUE, 0, value loaded into Q while reset is asserted. Truncated or zero-extended to WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset. 0 = reset asserted.
- en  input  1  clock enable. 1 = capture D on the rising edge.
- D  input  WIDTH  data input.
- Q  output  WIDTH  registered data.
- Qn  output  WIDTH  bitwise inverse of Q (combinational from Q).
- changed  output  1  registered strobe. High for exactly one cycle after a capture that altered Q.

Behaviour:
- Reset assertion (rst falling to 0):
  - Q = RESET_VALUE, Qn = ~RESET_VALUE, changed = 0.
  - Takes effect immediately, with no clock edge needed.
  - Holds while rst = 0, regardless of clk, en and D.
- Reset release (rst rising to 1): no output change until the next rising clk edge. Release is asynchronous to the flop; synchronizing release to clk is the integrator's responsibility.
- Rising clk edge with rst = 1 and en = 1: Q <= D. Latency is one clock from D to Q.
- Rising clk edge with rst = 1 and en = 0: Q holds its value. D is ignored.
- changed:
  - Set to 1 on an edge where en = 1 and D != Q (pre-edge value).
  - Set to 0 on every other edge.
  - Never high for two consecutive cycles unless Q changes again.
- Qn always equals ~Q, including during reset.
- Changes on en or D between edges have no effect; only the value at the rising edge matters.
- Reset mid-operation: an active-low reset coincident with a clock edge wins. Q = RESET_VALUE with no capture.
- en = 1 with D == Q: Q is unchanged and changed = 0.
- X or Z on en while rst = 1: Q must not be updated with a known value. Simulation propagates X.
- Power-up: Q is undefined until the first reset assertion. The system must assert rst at start-up.

Optional Feature:
- Macro: DFF_EN_SYNC_CLR_EN
- When defined, an extra input port is added: clr  input  1, synchronous clear, active-high.
  - On a rising edge with rst = 1 and clr = 1: Q <= RESET_VALUE, regardless of en.
  - changed is set if Q differed from RESET_VALUE.
  - clr has priority over en.
  - Asynchronous reset still has priority over clr.
- When not defined: the port is absent and behaviour is exactly as above.

Test Plan:
- Common setup: clk period 100 ns; WIDTH = 1, RESET_VALUE = 0 unless stated.
- Hold with en = 0:
  - Stimulus: rst = 0 for 50 ns, then rst = 1, en = 0, D = 1 for 3 edges.
  - Response: Q = 0, Qn = 1, changed = 0 throughout.
- Capture with en = 1:
  - Stimulus: from Q = 0, set D = 1, en = 1 before an edge.
  - Response: Q = 1 after that edge; changed = 1 for that cycle only; Q stays 1 and changed = 0 on the following 2 edges with D = 1.
- Enable drop:
  - Stimulus: Q = 1, en = 0, D = 0 for 2 edges.
  - Response: Q remains 1, changed = 0.
- Async reset mid-cycle:
  - Stimulus: Q = 1; drive rst = 0 at 30 ns after an edge with no clock edge in between.
  - Response: Q = 0 within the same delta/timestep, held while rst = 0 even with en = 1, D = 1 across 2 edges.
  - Then: after rst = 1, the next edge with en = 1, D = 1 gives Q = 1.
- WIDTH = 8, RESET_VALUE = 8'hA5:
  - Stimulus: reset; then en = 1 with D = 8'h3C, then D = 8'h3C again.
  - Response: Q = A5 during reset; Q = 3C with changed = 1 after the first edge; changed = 0 after the second edge; Qn = C3.
- With DFF_EN_SYNC_CLR_EN defined:
  - Stimulus: Q = 8'h3C, assert clr = 1 with en = 1, D = 8'hFF.
  - Response: Q = A5 after the edge, changed = 1.
